en_benzer_bulucu: RTL

Streaming best-match search stage placed directly downstream of `hammingbenzer16bit`. It latches a 16-bit key and accepts a stream of 16-bit candidate words over a valid/ready handshake. Each accepted word is scored by an internal `hammingbenzer16bit` instance (A = latched key, B = candidate). The block tracks the highest score and its index, counts words that meet a threshold, and reports the result with a one-cycle `done` pulse.

---
 rtl/en_benzer_bulucu.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/en_benzer_bulucu.sv
// Streaming best-match search: scores each accepted candidate against a latched key and
// reports the best score, its index and a threshold match count. Optional macro: EXACT_STOP_EN.

module hammingbenzer16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [4:0]  HB
);
  logic [15:0] eq_bits;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_eq
      assign eq_bits[gi] = ~(A[gi] ^ B[gi]);
    end
  endgenerate

  always_comb begin
    HB = 5'd0;
    for (int i = 0; i < 16; i++) begin
      HB = HB + {4'd0, eq_bits[i]};
    end
  end
endmodule

module en_benzer_bulucu #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      KEY,
  input  logic [4:0]       ESIK,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      DATA,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic [4:0]       BEST_HB,
  output logic [IDX_W-1:0] BEST_IDX,
  output logic [IDX_W-1:0] MATCH_CNT
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state_q, state_d;
  logic [15:0]      key_q, key_d;
  logic [4:0]       best_hb_q, best_hb_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [IDX_W-1:0] match_cnt_q, match_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             first_q, first_d;

  logic [4:0] hb;
  logic       hs;
  logic       stop;

  hammingbenzer16bit u_hb (
    .A  (key_q),
    .B  (DATA),
    .HB (hb)
  );

  // in_ready is decoded from the state register only, so the handshake never loops back.
  assign hs = in_valid & (state_q == RUN);

`ifdef EXACT_STOP_EN
  assign stop = in_last | (hb == 5'd16);
`else
  assign stop = in_last;
`endif

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    best_hb_d   = best_hb_q;
    best_idx_d  = best_idx_q;
    match_cnt_d = match_cnt_q;
    idx_d       = idx_q;
    first_d     = first_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d       = KEY;
          best_hb_d   = 5'd0;
          best_idx_d  = '0;
          match_cnt_d = '0;
          idx_d       = '0;
          first_d     = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          // Strict compare: ties keep the earlier index.
          if (first_q || (hb > best_hb_q)) begin
            best_hb_d  = hb;
            best_idx_d = idx_q;
          end
          if ((hb >= ESIK) && (match_cnt_q != {IDX_W{1'b1}})) begin
            match_cnt_d = match_cnt_q + IDX_W'(1);
          end
          idx_d   = idx_q + IDX_W'(1);
          first_d = 1'b0;
          if (stop || (idx_q == {IDX_W{1'b1}})) begin
            state_d = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= 16'd0;
      best_hb_q   <= 5'd0;
      best_idx_q  <= '0;
      match_cnt_q <= '0;
      idx_q       <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      best_hb_q   <= best_hb_d;
      best_idx_q  <= best_idx_d;
      match_cnt_q <= match_cnt_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
    end
  end

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign BEST_HB   = best_hb_q;
  assign BEST_IDX  = best_idx_q;
  assign MATCH_CNT = match_cnt_q;
endmodule
